// File: rtl/display_pkg.sv
// Shared constants for the two-digit seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [1:0] ANODE_OFF = 2'b11;
  localparam logic [1:0] ANODE_U   = 2'b10;
  localparam logic [1:0] ANODE_T   = 2'b01;

  typedef enum logic [1:0] {
    GAP_U  = 2'd0,
    SHOW_U = 2'd1,
    GAP_T  = 2'd2,
    SHOW_T = 2'd3
  } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low seven-segment pattern.
// Non-decimal codes render as a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; codes 10..15 fall through to the dash pattern
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed common-anode display driver.
// Digits are snapshotted once per frame; each slot opens with an anode-off gap.
module bcd_display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Units,
  input  logic [3:0] Tens,
  input  logic       Blank_lz,
  output logic [6:0] Seg,
  output logic [1:0] Anode,
  output logic       Frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP_CYCLES - 1);

  scan_state_t state;
  scan_state_t state_nxt;

  logic [CW-1:0] cnt;
  logic [3:0]    u_q;
  logic [3:0]    t_q;
  logic [3:0]    digit;
  logic [6:0]    digit_seg;
  logic [6:0]    seg_d;
  logic [1:0]    anode_d;
  logic          slot_end;
  logic          gap_end;
  logic          frame_start;
  logic          tens_blank;

  assign slot_end    = (cnt == CNT_LAST);
  assign gap_end     = (cnt == GAP_LAST);
  assign frame_start = (state == GAP_U) &&
                       (cnt == '0);
  assign tens_blank  = Blank_lz && (t_q == 4'd0);

  // Slot counter: free-running 0..REFRESH_DIV-1
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan state register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= GAP_U;
    end else begin
      state <= state_nxt;
    end
  end

  // Gap ends after GAP_CYCLES; show ends at slot wrap
  always_comb begin
    state_nxt = state;
    unique case (state)
      GAP_U:  if (gap_end)  state_nxt = SHOW_U;
      SHOW_U: if (slot_end) state_nxt = GAP_T;
      GAP_T:  if (gap_end)  state_nxt = SHOW_T;
      SHOW_T: if (slot_end) state_nxt = GAP_U;
      default:              state_nxt = GAP_U;
    endcase
  end

  // Capture both digits together at frame start
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      u_q <= 4'd0;
      t_q <= 4'd0;
    end else if (frame_start) begin
      u_q <= Units;
      t_q <= Tens;
    end
  end

  assign digit = (state == SHOW_T) ? t_q : u_q;

  bcd_to_7seg u_dec (
    .bcd (digit),
    .seg (digit_seg)
  );

  // Moore output decode; leading-zero blank uses live Blank_lz
  always_comb begin
    seg_d   = SEG_BLANK;
    anode_d = ANODE_OFF;
    unique case (state)
      GAP_U, GAP_T: begin
        seg_d   = SEG_BLANK;
        anode_d = ANODE_OFF;
      end
      SHOW_U: begin
        seg_d   = digit_seg;
        anode_d = ANODE_U;
      end
      SHOW_T: begin
        if (!tens_blank) begin
          seg_d   = digit_seg;
          anode_d = ANODE_T;
        end
      end
      default: begin
        seg_d   = SEG_BLANK;
        anode_d = ANODE_OFF;
      end
    endcase
  end

  // Registered outputs, one cycle behind the state register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      Seg        <= SEG_BLANK;
      Anode      <= ANODE_OFF;
      Frame_tick <= 1'b0;
    end else begin
      Seg        <= seg_d;
      Anode      <= anode_d;
      Frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomized bench for bcd_display_mux against a
// frame-position reference model.
module tb_bcd_display_mux;

  localparam int RD = 8;
  localparam int GC = 2;
  localparam int FR = 2 * RD;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Units = 4'd3;
  logic [3:0] Tens = 4'd7;
  logic       Blank_lz = 1'b0;
  logic [6:0] Seg;
  logic [1:0] Anode;
  logic       Frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  bit in_rst = 1'b1;
  logic [3:0] su = 4'd0;
  logic [3:0] st = 4'd0;

  bcd_display_mux #(
    .REFRESH_DIV (RD),
    .GAP_CYCLES  (GC)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Units      (Units),
    .Tens       (Tens),
    .Blank_lz   (Blank_lz),
    .Seg        (Seg),
    .Anode      (Anode),
    .Frame_tick (Frame_tick)
  );

  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dec(
    input logic [3:0] d
  );
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // n counts clock edges since reset release;
  // output after edge n shows frame position n-1.
  task automatic tick();
    int q;
    int pos;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_ft;
    @(posedge CLK);
    #1;
    e_seg = 7'h7F;
    e_an  = 2'b11;
    e_ft  = 1'b0;
    if (!in_rst) begin
      n++;
      q   = (n - 1) % FR;
      pos = q % RD;
      if (q == 0) begin
        su   = Units;
        st   = Tens;
        e_ft = 1'b1;
      end
      if (pos >= GC) begin
        if (q < RD) begin
          e_an  = 2'b10;
          e_seg = dec(su);
        end else if (!(Blank_lz && st == 4'd0)) begin
          e_an  = 2'b01;
          e_seg = dec(st);
        end
      end
    end
    check("seg", 32'(Seg), 32'(e_seg));
    check("anode", 32'(Anode), 32'(e_an));
    check("frame_tick", 32'(Frame_tick), 32'(e_ft));
    check("both_on", 32'(Anode == 2'b00), 32'd0);
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic to_pos(input int p);
    int guard = 0;
    while (((n - 1) % FR) != p && guard < 4 * FR) begin
      tick();
      guard++;
    end
    check("reach_pos", 32'((n - 1) % FR), 32'(p));
  endtask

  task automatic do_reset(input int k);
    Reset  = 1'b0;
    in_rst = 1'b1;
    #1;
    check("rst_seg", 32'(Seg), 32'h7F);
    check("rst_anode", 32'(Anode), 32'h3);
    check("rst_tick", 32'(Frame_tick), 32'h0);
    run(k);
    @(negedge CLK);
    Reset  = 1'b1;
    in_rst = 1'b0;
    n      = 0;
  endtask

  initial begin
    // held in reset for 100 ns
    run(10);
    @(negedge CLK);
    Reset  = 1'b1;
    in_rst = 1'b0;
    n      = 0;
    run(40);

    // units change during tens slot
    to_pos(12);
    Units = 4'd4;
    run(24);

    // leading-zero blank on and off
    Units    = 4'd5;
    Tens     = 4'd0;
    Blank_lz = 1'b1;
    run(2 * FR);
    Blank_lz = 1'b0;
    run(2 * FR);

    // non-decimal codes
    Units = 4'hC;
    Tens  = 4'hF;
    run(2 * FR);

    // reset during tens slot
    Units = 4'd9;
    Tens  = 4'd8;
    to_pos(12);
    do_reset(3);
    run(40);

    // random inputs with occasional resets
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(3) == 0)
        Units = 4'($urandom_range(15));
      if ($urandom_range(3) == 0)
        Tens = 4'($urandom_range(15));
      if ($urandom_range(7) == 0)
        Tens = 4'd0;
      if ($urandom_range(19) == 0)
        Blank_lz = ~Blank_lz;
      if ($urandom_range(299) == 0)
        do_reset(int'($urandom_range(1, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
